fir_stream_ctrl: RTL and testbench

//  Driver/consumer for the 13-tap floating-point FIR pipeline. Owns the coefficient bank and feeds it to the filter.

---
 rtl/fir_pkg.sv | 9 +
 rtl/fir_tag_pipe.sv | 24 ++
 rtl/fir_stream_ctrl.sv | 81 ++++++++
 tb/tb_fir_stream_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared sizes and state encoding for the FIR stream controller
package fir_pkg;
  localparam int TAPS = 13;
  localparam int LATENCY = 7;
  localparam int DRAIN_LEN = 13;
  localparam int CFG_AW = 4;
  localparam int CNT_W = $clog2(DRAIN_LEN);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/fir_tag_pipe.sv
// fir_tag_pipe: {valid,last} shift register advanced in lockstep with the filter
module fir_tag_pipe #(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);
  logic [DEPTH-1:0] v, l;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v <= '0;
      l <= '0;
    end else if (adv) begin
      v <= {v[DEPTH-2:0], in_valid};
      l <= {l[DEPTH-2:0], in_last};
    end
  assign out_valid = v[DEPTH-1];
  assign out_last  = l[DEPTH-1];
endmodule

// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: coefficient bank, sample streaming, result return and drain around an external FIR pipeline
module fir_stream_ctrl
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [CFG_AW-1:0]    cfg_addr,
  input  logic [31:0]          cfg_data,
  input  logic                 cfg_go,
  output logic                 cfg_err,
  output logic                 busy,
  output logic                 done,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_data,
  input  logic                 s_last,
  output logic [32*TAPS-1:0]   coeff_flat,
  output logic [31:0]          fir_in,
  output logic                 fir_start,
  output logic                 fir_hold,
  input  logic [31:0]          fir_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [31:0]          m_data,
  output logic                 m_last
);
  state_t state, state_nx;
  logic [TAPS-1:0][31:0] coeff;
  logic [CNT_W-1:0] cnt;
  logic out_pend, slot, adv, run, drain, wr_ok, tap_valid, tap_last;
  assign run   = state == RUN;
  assign drain = state == DRAIN;
  assign slot  = !out_pend || m_ready;
  assign adv   = slot && (drain || (run && s_valid));
  assign wr_ok = state == IDLE && cfg_addr < CFG_AW'(TAPS);
  always_comb begin
    s_ready    = run && slot;
    fir_in     = run ? s_data : '0;
    fir_start  = run || drain;
    fir_hold   = !adv;
    busy       = state != IDLE;
    m_valid    = out_pend;
    m_data     = fir_out;
    coeff_flat = coeff;
    state_nx   = (state == IDLE && cfg_go)       ? RUN :
                 (run && adv && s_last)          ? DRAIN :
                 (drain && adv && cnt == '0)     ? IDLE : state;
  end
  // Stage LATENCY-2 is the last one read, so the pipe stops there.
  fir_tag_pipe #(.DEPTH(LATENCY - 1)) u_tags (
    .clk      (clk),
    .rst      (reset),
    .adv      (adv),
    .in_valid (run),
    .in_last  (run && s_last),
    .out_valid(tap_valid),
    .out_last (tap_last)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      coeff    <= '0;
      cnt      <= '0;
      out_pend <= 1'b0;
      m_last   <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state   <= state_nx;
      done    <= drain && adv && cnt == '0;
      cfg_err <= cfg_we && !wr_ok;
      if (cfg_we && wr_ok) coeff[cfg_addr] <= cfg_data;
      if (run && adv && s_last) cnt <= CNT_W'(DRAIN_LEN - 1);
      else if (drain && adv) cnt <= cnt - CNT_W'(1);
      if (adv && tap_valid) begin
        out_pend <= 1'b1;
        m_last   <= tap_last;
      end else if (out_pend && m_ready) out_pend <= 1'b0;
    end
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb_fir_stream_ctrl: directed vector checks of fir_stream_ctrl driving an integer-valued FIR model
module tb_fir_stream_ctrl;
  import fir_pkg::*;
  typedef struct {
    logic [31:0] din;
    logic        lin;
    logic [31:0] dout;
    logic        lout;
  } vec_t;
  logic clk = 0, reset = 1, cfg_we = 0, cfg_go = 0, s_valid = 0, s_last = 0, m_ready = 1;
  logic [CFG_AW-1:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0, s_data = '0, fir_out, fir_in, m_data;
  logic cfg_err, busy, done, s_ready, fir_start, fir_hold, m_valid, m_last;
  logic [32*TAPS-1:0] coeff_flat, snap;
  int errors = 0, checks = 0, cyc = 0, last_acc = 0;
  logic [31:0] q_data[$];
  logic q_last[$];
  vec_t v1[TAPS], v2[TAPS];
  logic [31:0] ramp[TAPS] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                              32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000,
                              32'h41300000, 32'h41400000, 32'h41500000};
  logic [31:0] evens[TAPS] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000,
                               32'h41400000, 32'h41600000, 32'h41800000, 32'h41900000, 32'h41A00000,
                               32'h41B00000, 32'h41C00000, 32'h41D00000};
  logic [31:0] dl[TAPS];
  int yp[LATENCY];

  fir_stream_ctrl dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_go(cfg_go), .cfg_err(cfg_err), .busy(busy), .done(done), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .coeff_flat(coeff_flat),
    .fir_in(fir_in), .fir_start(fir_start), .fir_hold(fir_hold), .fir_out(fir_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int f2i(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'd0, 1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] i2f(input int v);
    int e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 31; b++) if (v[b]) e = b;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(e + 127), m[22:0]};
  endfunction

  // Filter model: result of the sample taken on advance n appears on fir_out after advance n+6.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) dl[k] <= '0;
      for (int i = 0; i < LATENCY; i++) yp[i] <= 0;
    end else if (fir_start && !fir_hold) begin
      int acc;
      acc = f2i(coeff_flat[31:0]) * f2i(fir_in);
      for (int k = 1; k < TAPS; k++) acc += f2i(coeff_flat[32*k +: 32]) * f2i(dl[k-1]);
      dl[0] <= fir_in;
      for (int k = 1; k < TAPS; k++) dl[k] <= dl[k-1];
      yp[0] <= acc;
      for (int i = 1; i < LATENCY; i++) yp[i] <= yp[i-1];
    end
  end
  always_comb fir_out = i2f(yp[LATENCY-1]);

  always @(negedge clk) if (m_valid && m_ready) begin
    q_data.push_back(m_data);
    q_last.push_back(m_last);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int which, input bit gap);
    for (int i = 0; i < TAPS; i++) begin
      bit acc;
      int t;
      s_valid = 1;
      s_data  = which != 0 ? v2[i].din : v1[i].din;
      s_last  = which != 0 ? v2[i].lin : v1[i].lin;
      acc = 0;
      t = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = s_ready;
        t++;
      end
      chk($sformatf("accept%0d", i), acc, 1);
      if (acc && s_last) last_acc = cyc + 1;
      step;
      s_valid = 0;
      s_last  = 0;
      if (gap && i < TAPS - 1) repeat (2) begin
        @(negedge clk);
        chk("gap_hold", fir_hold, 1);
        step;
      end
    end
  endtask

  task automatic stall;
    bit seen;
    int t;
    logic [31:0] held;
    seen = 0;
    t = 0;
    while (!seen && t < 200) begin
      @(negedge clk);
      seen = m_valid;
      t++;
    end
    chk("bp_seen", seen, 1);
    held = m_data;
    chk("bp_first", held, ramp[0]);
    repeat (5) begin
      step;
      @(negedge clk);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_hold", fir_hold, 1);
      chk("bp_valid", m_valid, 1);
      chk("bp_data", m_data, held);
    end
    step;
    m_ready = 1;
  endtask

  task automatic wait_done;
    bit seen;
    int t;
    seen = 0;
    t = 0;
    while (!seen && t < 300) begin
      @(negedge clk);
      seen = done;
      t++;
    end
    chk("done_seen", seen, 1);
    chk("done_delay", cyc - last_acc, DRAIN_LEN);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    step;
  endtask

  task automatic compare(input int which);
    chk("result_count", q_data.size(), TAPS);
    for (int i = 0; i < TAPS && i < q_data.size(); i++) begin
      chk($sformatf("data%0d", i), q_data[i], which != 0 ? v2[i].dout : v1[i].dout);
      chk($sformatf("last%0d", i), q_last[i], which != 0 ? v2[i].lout : v1[i].lout);
    end
  endtask

  task automatic do_run(input int which, input bit gap, input bit stall_en, input bit cfg_probe);
    q_data.delete();
    q_last.delete();
    m_ready = !stall_en;
    cfg_go = 1;
    step;
    cfg_go = 0;
    if (cfg_probe) begin
      cfg_we = 1;
      cfg_addr = 4'd2;
      cfg_data = 32'hDEADBEEF;
      step;
      cfg_we = 0;
      @(negedge clk);
      chk("run_busy", busy, 1);
      chk("err_run", cfg_err, 1);
      chk("coeff2_kept", coeff_flat[95:64], ramp[2]);
      step;
      @(negedge clk);
      chk("err_run_clear", cfg_err, 0);
      step;
    end
    fork
      stream(which, gap);
      if (stall_en) stall();
    join
    wait_done();
    compare(which);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < TAPS; i++) begin
      v1[i] = '{i == 0 ? 32'h3F800000 : 32'h0, i == TAPS - 1, ramp[i], i == TAPS - 1};
      v2[i] = '{32'h40000000, i == TAPS - 1, evens[i], i == TAPS - 1};
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("rst_hold", fir_hold, 1);
    chk("rst_start", fir_start, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_fir_in", fir_in, 0);
    chk("rst_coeff", coeff_flat == '0, 1);
    step;
    for (int k = 0; k < TAPS; k++) begin
      cfg_we = 1;
      cfg_addr = CFG_AW'(k);
      cfg_data = ramp[k];
      step;
    end
    cfg_we = 0;
    @(negedge clk);
    for (int k = 0; k < TAPS; k++) chk($sformatf("coeff%0d", k), coeff_flat[32*k +: 32], ramp[k]);
    chk("cfg_ok_err", cfg_err, 0);
    snap = coeff_flat;
    step;
    cfg_we = 1;
    cfg_addr = 4'd13;
    cfg_data = 32'h12345678;
    step;
    cfg_we = 0;
    @(negedge clk);
    chk("err_addr", cfg_err, 1);
    chk("coeff_kept", coeff_flat == snap, 1);
    step;
    @(negedge clk);
    chk("err_addr_clear", cfg_err, 0);
    step;
    do_run(0, 0, 0, 1);
    do_run(0, 0, 1, 0);
    do_run(0, 1, 0, 0);
    for (int k = 0; k < TAPS; k++) begin
      cfg_we = 1;
      cfg_addr = CFG_AW'(k);
      cfg_data = 32'h3F800000;
      step;
    end
    cfg_we = 0;
    do_run(1, 0, 0, 0);
    m_ready = 1;
    cfg_go = 1;
    step;
    cfg_go = 0;
    s_valid = 1;
    s_data = 32'h40000000;
    repeat (4) step;
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_hold", fir_hold, 1);
      chk("mid_rst_start", fir_start, 0);
      chk("mid_rst_s_ready", s_ready, 0);
      chk("mid_rst_m_valid", m_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      step;
    end
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
      step;
    end
    s_valid = 0;
    chk("post_rst_coeff", coeff_flat == '0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
